// File: rtl/i2s_tx_feeder.sv
// Stream-to-I2S feeder: buffers stereo pairs and hands exactly one pair per I2S frame to the transmitter.
// Optional macro I2S_FEED_HOLD_LAST_EN: on underrun, hold the last played pair instead of muting.
module i2s_tx_feeder #(
  parameter int DATA_BITS   = 24,
  parameter int FIFO_DEPTH  = 8,
  parameter int START_LEVEL = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          bclk_falling,
  input  logic                          lrclk,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_left,
  input  logic [DATA_BITS-1:0]          s_right,
  output logic [DATA_BITS-1:0]          left_data,
  output logic [DATA_BITS-1:0]          right_data,
  output logic                          running,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] START_LVL = LW'(START_LEVEL);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [DATA_BITS-1:0]   left_q, left_d, right_q, right_d;
  logic                   lrclk_prev_q, underrun_q, underrun_d;
  logic [15:0]            ucnt_q, ucnt_d;
  logic [2*DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [2*DATA_BITS-1:0] rd_pair;
  logic                   push, pop, flush, frame_tick;

  // The transmitter loads right_data on this strobe, so the new pair lands after the old right slot.
  assign frame_tick = bclk_falling & lrclk & ~lrclk_prev_q;
  assign s_ready    = enable & (state_q != IDLE) & (level_q < FULL_LVL);
  assign push       = s_valid & s_ready;
  assign rd_pair    = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    right_d    = right_q;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;
    pop        = 1'b0;
    flush      = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      flush   = 1'b1;
      left_d  = '0;
      right_d = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = PRIME;
        PRIME: begin
          if (frame_tick && level_q >= START_LVL) begin
            pop     = 1'b1;
            left_d  = rd_pair[2*DATA_BITS-1:DATA_BITS];
            right_d = rd_pair[DATA_BITS-1:0];
            state_d = RUN;
          end
        end
        RUN: begin
          if (frame_tick) begin
            if (level_q != '0) begin
              pop     = 1'b1;
              left_d  = rd_pair[2*DATA_BITS-1:DATA_BITS];
              right_d = rd_pair[DATA_BITS-1:0];
            end else begin
`ifdef I2S_FEED_HOLD_LAST_EN
              left_d  = left_q;
              right_d = right_q;
`else
              left_d  = '0;
              right_d = '0;
`endif
              underrun_d = 1'b1;
              ucnt_d     = (ucnt_q == 16'hFFFF) ? ucnt_q : ucnt_q + 16'd1;
              state_d    = PRIME;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      left_q       <= '0;
      right_q      <= '0;
      lrclk_prev_q <= 1'b0;
      underrun_q   <= 1'b0;
      ucnt_q       <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      left_q     <= left_d;
      right_q    <= right_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
      if (bclk_falling) lrclk_prev_q <= lrclk;
    end
  end

  // Sample storage carries no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_left, s_right};
  end

  assign left_data      = left_q;
  assign right_data     = right_q;
  assign running        = (state_q == RUN);
  assign underrun       = underrun_q;
  assign fifo_level     = level_q;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Randomized bench for i2s_tx_feeder against a queue-based reference model of the feeder's rules.
module tb_i2s_tx_feeder;

  localparam int DW    = 24;
  localparam int DEPTH = 8;
  localparam int START = 4;

  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic          bclk_falling = 1'b0, lrclk = 1'b0, s_valid = 1'b0;
  logic [DW-1:0] s_left = '0, s_right = '0;
  logic          s_ready, running, underrun;
  logic [DW-1:0] left_data, right_data;
  logic [3:0]    fifo_level;
  logic [15:0]   underrun_count;

  i2s_tx_feeder #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH), .START_LEVEL(START)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bclk_falling(bclk_falling), .lrclk(lrclk),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .left_data(left_data), .right_data(right_data), .running(running), .underrun(underrun),
    .fifo_level(fifo_level), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // reference model
  logic [2*DW-1:0] m_q[$];
  bit              m_active, m_play, m_lrprev, m_ur;
  logic [DW-1:0]   m_l, m_r;
  logic [15:0]     m_cnt;

  // stimulus controls
  int unsigned pushes_left = 0, prob = 100;
  bit          gen_on = 1'b1, ppf = 1'b0, rand_data = 1'b0, man_bclk = 1'b0, man_lr = 1'b0;
  logic [31:0] g_cnt = '0;
  logic [DW-1:0] seq = 24'd1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 0; m_play = 0; m_lrprev = 0; m_ur = 0;
    m_l = '0; m_r = '0; m_cnt = '0;
  endtask

  task automatic model_step();
    bit tick, acc;
    logic [2*DW-1:0] pr;
    tick = bclk_falling && lrclk && !m_lrprev;
    if (bclk_falling) m_lrprev = lrclk;
    m_ur = 0;
    acc  = enable && m_active && (m_q.size() < DEPTH) && s_valid;
    if (!enable) begin
      m_q.delete(); m_active = 0; m_play = 0; m_l = '0; m_r = '0;
    end else if (!m_active) begin
      m_active = 1;
    end else begin
      if (tick) begin
        if (m_q.size() >= (m_play ? 1 : START)) begin
          pr = m_q.pop_front();
          m_l = pr[2*DW-1:DW]; m_r = pr[DW-1:0]; m_play = 1;
        end else if (m_play) begin
`ifndef I2S_FEED_HOLD_LAST_EN
          m_l = '0; m_r = '0;
`endif
          m_ur = 1; m_play = 0;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      if (acc) m_q.push_back({s_left, s_right});
    end
    if (acc) begin
      seq = seq + 24'd1;
      if (pushes_left != 0) pushes_left--;
    end
  endtask

  task automatic compare();
    chk("left", left_data, m_l);
    chk("right", right_data, m_r);
    chk("running", running, m_play);
    chk("underrun", underrun, m_ur);
    chk("level", fifo_level, m_q.size());
    chk("ucnt", underrun_count, m_cnt);
    chk("ready", s_ready, enable && m_active && (m_q.size() < DEPTH));
  endtask

  // One clock: model sees the inputs present at the edge, new inputs follow 1ns later, outputs checked on negedge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    if (gen_on) begin
      g_cnt = g_cnt + 1;
      bclk_falling = g_cnt[0];
      lrclk = g_cnt[3];
      if (ppf && g_cnt[3:0] == 4'd0) pushes_left++;
    end else begin
      bclk_falling = man_bclk;
      lrclk = man_lr;
    end
    s_valid = (pushes_left != 0) && ($urandom_range(99) < prob);
    s_left  = rand_data ? DW'($urandom) : seq;
    s_right = rand_data ? DW'($urandom) : (24'h100000 | seq);
    @(negedge clk);
    compare();
  endtask

  initial begin
    model_reset();
    repeat (3) cycle();
    chk("rst_level", fifo_level, 0);
    chk("rst_left", left_data, 0);
    chk("rst_run", running, 0);
    rst_n = 1'b1;

    // priming with four sequential pairs
    enable = 1'b1; pushes_left = 4;
    for (int i = 0; i < 200; i++) begin if (running) break; cycle(); end
    chk("t1_run", running, 1);
    chk("t1_left", left_data, 24'h000001);
    chk("t1_right", right_data, 24'h100001);
    chk("t1_level", fifo_level, 3);

    // drain to underrun
    for (int i = 0; i < 200; i++) begin if (underrun) break; cycle(); end
    chk("t3_ur", underrun, 1);
    chk("t3_ucnt", underrun_count, 1);
    chk("t3_run", running, 0);
`ifdef I2S_FEED_HOLD_LAST_EN
    chk("t3_left", left_data, 24'h000004);
    chk("t3_right", right_data, 24'h100004);
`else
    chk("t3_left", left_data, 0);
    chk("t3_right", right_data, 0);
`endif
    pushes_left = 4;
    for (int i = 0; i < 200; i++) begin if (running) break; cycle(); end
    chk("t3_restart", running, 1);
    chk("t3_rleft", left_data, 24'h000005);

    // one pair per frame
    ppf = 1'b1;
    repeat (320) cycle();
    ppf = 1'b0;
    chk("t2_ucnt", underrun_count, 1);
    chk("t2_run", running, 1);

    // fill to full with no frame ticks, then pop with push pending
    gen_on = 1'b0; man_bclk = 1'b1; man_lr = 1'b0;
    cycle();
    man_bclk = 1'b0; pushes_left = 100;
    repeat (20) cycle();
    chk("t4_full", fifo_level, 8);
    chk("t4_ready", s_ready, 0);
    man_lr = 1'b1; man_bclk = 1'b1;
    cycle();
    man_bclk = 1'b0;
    cycle();
    chk("t4_pop", fifo_level, 7);
    cycle();
    chk("t4_refill", fifo_level, 8);

    // disable mid-run at level 5
    pushes_left = 0; gen_on = 1'b1;
    for (int i = 0; i < 200; i++) begin if (fifo_level == 5) break; cycle(); end
    chk("t5_lvl5", fifo_level, 5);
    enable = 1'b0;
    cycle();
    chk("t5_run", running, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_left", left_data, 0);
    chk("t5_ready", s_ready, 0);
    enable = 1'b1; pushes_left = 3;
    repeat (64) cycle();
    chk("t5_noplay", running, 0);
    chk("t5_lvl3", fifo_level, 3);
    pushes_left = 1;
    for (int i = 0; i < 100; i++) begin if (running) break; cycle(); end
    chk("t5_play", running, 1);

    // random traffic with random data and enable toggling
    rand_data = 1'b1; pushes_left = 32'hFFFF_FFFF;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) prob = $urandom_range(100);
      if (enable) begin
        if ($urandom_range(299) == 0) enable = 1'b0;
      end else if ($urandom_range(19) == 0) enable = 1'b1;
      cycle();
    end

    // asynchronous reset while running
    enable = 1'b1; prob = 100;
    for (int i = 0; i < 300; i++) begin if (running) break; cycle(); end
    chk("t6_pre_run", running, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_left", left_data, 0);
    chk("t6_right", right_data, 0);
    chk("t6_run", running, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_ucnt", underrun_count, 0);
    chk("t6_ur", underrun, 0);
    model_reset();
    repeat (2) cycle();
    enable = 1'b0; rst_n = 1'b1;
    repeat (2) cycle();
    chk("t6_empty", fifo_level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
